// File: rtl/traffic_pkg.sv
// Shared traffic-controller types: light encodings, phase enum, BCD helpers
// and 7-segment override codes.
package traffic_pkg;

  localparam int unsigned RED = 2;
  localparam int unsigned YEL = 1;
  localparam int unsigned GRN = 0;

  localparam logic [2:0] LIGHT_RED = 3'(1 << RED);
  localparam logic [2:0] LIGHT_YEL = 3'(1 << YEL);
  localparam logic [2:0] LIGHT_GRN = 3'(1 << GRN);

  typedef enum logic [2:0] {
    PH_MG,
    PH_MY,
    PH_CG,
    PH_CY,
    PH_INVALID
  } phase_e;

  // {main, cross} light vectors that identify each phase
  localparam logic [2:0] MG_MAIN  = LIGHT_GRN;
  localparam logic [2:0] MG_CROSS = LIGHT_RED;
  localparam logic [2:0] MY_MAIN  = LIGHT_YEL;
  localparam logic [2:0] MY_CROSS = LIGHT_RED;
  localparam logic [2:0] CG_MAIN  = LIGHT_RED;
  localparam logic [2:0] CG_CROSS = LIGHT_GRN;
  localparam logic [2:0] CY_MAIN  = LIGHT_RED;
  localparam logic [2:0] CY_CROSS = LIGHT_YEL;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    SEG_DIGIT,
    SEG_OVR_BLANK,
    SEG_OVR_DASH
  } seg_ovr_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = 4'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

  function automatic phase_e phase_decode(input logic [2:0] main_l, input logic [2:0] cross_l);
    if (main_l == MG_MAIN && cross_l == MG_CROSS) return PH_MG;
    if (main_l == MY_MAIN && cross_l == MY_CROSS) return PH_MY;
    if (main_l == CG_MAIN && cross_l == CG_CROSS) return PH_CG;
    if (main_l == CY_MAIN && cross_l == CY_CROSS) return PH_CY;
    return PH_INVALID;
  endfunction

  // BCD decrement with tens borrow; caller guarantees value != 00
  function automatic bcd2_t bcd2_dec(input bcd2_t v);
    bcd2_t r;
    if (v.ones == 4'd0) begin
      r.ones = 4'd9;
      r.tens = v.tens - 4'd1;
    end else begin
      r.ones = v.ones - 4'd1;
      r.tens = v.tens;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_countdown_display_if.sv
// Light-state inputs and multiplexed 7-segment outputs of the countdown display.
interface phase_countdown_display_if;
  logic       tick_1Hz;
  logic [2:0] main_st;
  logic [2:0] cross_st;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output tick_1Hz, main_st, cross_st, input seg, an, dp);
  modport slave  (input tick_1Hz, main_st, cross_st, output seg, an, dp);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment {g,f,e,d,c,b,a}, with
// blank/dash override.
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] digit,
  input  seg_ovr_e   ovr,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (ovr)
      SEG_OVR_DASH:  seg_c = SEG_DASH;
      SEG_OVR_BLANK: seg_c = SEG_BLANK;
      default: begin
        case (digit)
          4'd0: seg_c = 7'b1000000;
          4'd1: seg_c = 7'b1111001;
          4'd2: seg_c = 7'b0100100;
          4'd3: seg_c = 7'b0110000;
          4'd4: seg_c = 7'b0011001;
          4'd5: seg_c = 7'b0010010;
          4'd6: seg_c = 7'b0000010;
          4'd7: seg_c = 7'b1111000;
          4'd8: seg_c = 7'b0000000;
          4'd9: seg_c = 7'b0010000;
          default: seg_c = SEG_BLANK;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/phase_countdown_display.sv
// Identifies the traffic phase from the light vectors, counts its remaining
// seconds in BCD and drives a 4-digit multiplexed active-low 7-segment display.
module phase_countdown_display
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned T_MG       = 10,
  parameter int unsigned T_MY       = 3,
  parameter int unsigned T_CG       = 5,
  parameter int unsigned T_CY       = 3
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  phase_countdown_display_if.slave   bus
);

  localparam int unsigned REFRESH_CYC = CLK_HZ / (4 * REFRESH_HZ);
  localparam int unsigned REF_W       = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  localparam bcd2_t LOAD_MG = to_bcd2(T_MG);
  localparam bcd2_t LOAD_MY = to_bcd2(T_MY);
  localparam bcd2_t LOAD_CG = to_bcd2(T_CG);
  localparam bcd2_t LOAD_CY = to_bcd2(T_CY);

  logic [1:0] tick_sync;
  logic       tick_prev;
  logic [2:0] main_s1, main_s2;
  logic [2:0] cross_s1, cross_s2;
  logic       tick_event_c;

  phase_e     phase_q;
  phase_e     phase_dec_c;
  bcd2_t      count_q;
  bcd2_t      load_c;

  logic [REF_W-1:0] refresh_q;
  logic [1:0]       slot_q;
  logic             refresh_wrap_c;
  logic [1:0]       slot_next_c;
  logic [3:0]       an_next_c;
  logic [3:0]       digit_c;
  seg_ovr_e         ovr_c;
  logic [6:0]       seg_c;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;
  logic             dp_q;

  // Two-flop synchronisers plus one extra flop for tick edge detection
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      tick_sync <= '0;
      tick_prev <= 1'b0;
      main_s1   <= '0;
      main_s2   <= '0;
      cross_s1  <= '0;
      cross_s2  <= '0;
    end else begin
      tick_sync <= {tick_sync[0], bus.tick_1Hz};
      tick_prev <= tick_sync[1];
      main_s1   <= bus.main_st;
      main_s2   <= main_s1;
      cross_s1  <= bus.cross_st;
      cross_s2  <= cross_s1;
    end
  end

  assign tick_event_c = tick_sync[1] & ~tick_prev;
  assign phase_dec_c  = phase_decode(main_s2, cross_s2);

  always_comb begin
    load_c = '0;
    case (phase_dec_c)
      PH_MG:   load_c = LOAD_MG;
      PH_MY:   load_c = LOAD_MY;
      PH_CG:   load_c = LOAD_CG;
      PH_CY:   load_c = LOAD_CY;
      default: load_c = '0;
    endcase
  end

  // A phase change reloads and wins over a coincident tick; count saturates at 00
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_INVALID;
      count_q <= '0;
    end else if (phase_dec_c != phase_q) begin
      phase_q <= phase_dec_c;
      count_q <= load_c;
    end else if (tick_event_c && phase_q != PH_INVALID && count_q != '0) begin
      count_q <= bcd2_dec(count_q);
    end
  end

  assign refresh_wrap_c = (refresh_q == REF_W'(REFRESH_CYC - 1));
  assign slot_next_c    = refresh_wrap_c ? slot_q + 2'd1 : slot_q;

  // Select anode and digit source for the slot that is live after this edge
  always_comb begin
    an_next_c = 4'b1111;
    digit_c   = count_q.ones;
    ovr_c     = SEG_OVR_BLANK;
    case (slot_next_c)
      2'd0: begin
        an_next_c = 4'b1110;
        digit_c   = count_q.ones;
        ovr_c     = (phase_q == PH_INVALID) ? SEG_OVR_DASH : SEG_DIGIT;
      end
      2'd1: begin
        an_next_c = 4'b1101;
        digit_c   = count_q.tens;
        if (phase_q == PH_INVALID)      ovr_c = SEG_OVR_DASH;
        else if (count_q.tens == 4'd0)  ovr_c = SEG_OVR_BLANK;
        else                            ovr_c = SEG_DIGIT;
      end
      default: begin
        an_next_c = 4'b1111;
        ovr_c     = SEG_OVR_BLANK;
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .digit (digit_c),
    .ovr   (ovr_c),
    .seg_c (seg_c)
  );

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      slot_q    <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      refresh_q <= refresh_wrap_c ? '0 : refresh_q + REF_W'(1);
      slot_q    <= slot_next_c;
      an_q      <= an_next_c;
      seg_q     <= seg_c;
      dp_q      <= 1'b1;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule
